// File: rtl/alu_pkg.sv
// Shared definitions for the 9-bit ALU issue path: opcode encodings, FSM states
// and the operand-b source decode.
package alu_pkg;

    localparam int WIDTH = 9;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_NOT  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_MOV  = 4'd4;
    localparam logic [3:0] OP_SHL  = 4'd5;
    localparam logic [3:0] OP_SHR  = 4'd6;
    localparam logic [3:0] OP_SUB  = 4'd7;
    localparam logic [3:0] OP_ADDI = 4'd8;
    localparam logic [3:0] OP_SUBI = 4'd9;
    localparam logic [3:0] OP_LDI  = 4'd10;
    localparam logic [3:0] OP_NOP  = 4'd11;
    // Every encoding at or above this value is illegal.
    localparam logic [3:0] OP_ILLEGAL_MIN = 4'd12;

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    function automatic logic is_imm_op(input logic [3:0] op);
        return (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_LDI);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// NREGS x WIDTH register file: two combinational operand reads, one debug read,
// one synchronous write port; asynchronously cleared by reset.
module alu_regfile #(
    parameter int WIDTH = 9,
    parameter int NREGS = 8,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_a_i,
    output logic [WIDTH-1:0] rdata_a_o,
    input  logic [AW-1:0]    raddr_b_i,
    output logic [WIDTH-1:0] rdata_b_o,
    input  logic [AW-1:0]    dbg_addr_i,
    output logic [WIDTH-1:0] dbg_data_o
);

    logic [WIDTH-1:0] mem_q [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o  = mem_q[raddr_a_i];
    assign rdata_b_o  = mem_q[raddr_b_i];
    assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller driving one 9-bit ALU: accepts an instruction in IDLE,
// registers operands (EXEC), captures the ALU result and writes it back (WB).
module alu_issue_ctrl #(
    parameter int WIDTH = alu_pkg::WIDTH,
    parameter int NREGS = 8,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [3:0]       instr_op,
    input  logic [AW-1:0]    instr_rd,
    input  logic [AW-1:0]    instr_ra,
    input  logic [AW-1:0]    instr_rb,
    input  logic [WIDTH-1:0] instr_imm,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_out,
    output logic             done,
    output logic             err,
    output logic             zero,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);
    import alu_pkg::*;

    state_t           state_q;
    logic             ready_q, done_q, err_q, zero_q, illegal_q;
    logic [AW-1:0]    rd_q;
    logic [WIDTH-1:0] a_q, b_q, result_q;
    logic [3:0]       op_q;

    logic [WIDTH-1:0] rdata_a, rdata_b, opb_d;
    logic             accept, wb_write;

    assign accept   = instr_valid && ready_q;
    assign opb_d    = is_imm_op(instr_op) ? instr_imm : rdata_b;
    assign wb_write = (state_q == WB) && !illegal_q && (op_q != OP_NOP);

    alu_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .we_i       (wb_write),
        .waddr_i    (rd_q),
        .wdata_i    (result_q),
        .raddr_a_i  (instr_ra),
        .rdata_a_o  (rdata_a),
        .raddr_b_i  (instr_rb),
        .rdata_b_o  (rdata_b),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data)
    );

    // Reset parks the ALU on MOV 0,0 so it never sees the hold opcode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ready_q   <= 1'b1;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= OP_MOV;
            rd_q      <= '0;
            illegal_q <= 1'b0;
            result_q  <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q       <= rdata_a;
                        b_q       <= opb_d;
                        op_q      <= instr_op;
                        rd_q      <= instr_rd;
                        illegal_q <= (instr_op >= OP_ILLEGAL_MIN);
                        ready_q   <= 1'b0;
                        state_q   <= EXEC;
                    end
                end
                EXEC: begin
                    result_q <= alu_out;
                    state_q  <= WB;
                end
                WB: begin
                    if (illegal_q) begin
                        err_q <= 1'b1;
                    end else begin
                        done_q <= 1'b1;
                        if (op_q != OP_NOP) begin
                            zero_q <= (result_q == '0);
                        end
                    end
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign instr_ready = ready_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_opcode  = op_q;
    assign done        = done_q;
    assign err         = err_q;
    assign zero        = zero_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl paired with a behavioural 9-bit ALU.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] instr_op;
    logic [2:0] instr_rd, instr_ra, instr_rb;
    logic [8:0] instr_imm;
    logic [8:0] alu_a, alu_b, alu_out;
    logic [3:0] alu_opcode;
    logic       done, err, zero;
    logic [2:0] dbg_addr;
    logic [8:0] dbg_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_rd    (instr_rd),
        .instr_ra    (instr_ra),
        .instr_rb    (instr_rb),
        .instr_imm   (instr_imm),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_opcode  (alu_opcode),
        .alu_out     (alu_out),
        .done        (done),
        .err         (err),
        .zero        (zero),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    // Behavioural stand-in for the 9-bit ALU, results modulo 512.
    always_comb begin
        alu_out = '0;
        case (alu_opcode)
            OP_AND:  alu_out = alu_a & alu_b;
            OP_OR:   alu_out = alu_a | alu_b;
            OP_NOT:  alu_out = ~alu_a;
            OP_ADD:  alu_out = alu_a + alu_b;
            OP_MOV:  alu_out = alu_a;
            OP_SHL:  alu_out = alu_a << 1;
            OP_SHR:  alu_out = alu_a >> 1;
            OP_SUB:  alu_out = alu_a - alu_b;
            OP_ADDI: alu_out = alu_a + alu_b;
            OP_SUBI: alu_out = alu_a - alu_b;
            OP_LDI:  alu_out = alu_b;
            default: alu_out = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reg_is(input logic [2:0] r, input logic [8:0] exp, input string tag);
        dbg_addr = r;
        #1;
        chk(tag, 16'(dbg_data), 16'(exp));
    endtask

    // Issues one instruction from IDLE and walks it through EXEC and WB.
    task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] ra,
                         input logic [2:0] rb, input logic [8:0] imm,
                         input logic exp_done, input logic exp_err, input string tag);
        @(posedge clk); #1;
        chk({tag, ".rdy_in"}, 16'(instr_ready), 16'd1);
        instr_op = op; instr_rd = rd; instr_ra = ra; instr_rb = rb; instr_imm = imm;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        chk({tag, ".rdy_exec"}, 16'(instr_ready), 16'd0);
        @(posedge clk); #1;
        chk({tag, ".rdy_wb"}, 16'(instr_ready), 16'd0);
        chk({tag, ".done_wb"}, 16'(done), 16'd0);
        @(posedge clk); #1;
        chk({tag, ".done"}, 16'(done), 16'(exp_done));
        chk({tag, ".err"}, 16'(err), 16'(exp_err));
        chk({tag, ".rdy_out"}, 16'(instr_ready), 16'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        instr_valid = 1'b0;
        instr_op = '0; instr_rd = '0; instr_ra = '0; instr_rb = '0; instr_imm = '0;
        dbg_addr = '0;

        #12;
        chk("rst.ready", 16'(instr_ready), 16'd1);
        chk("rst.alu_a", 16'(alu_a), 16'd0);
        chk("rst.alu_b", 16'(alu_b), 16'd0);
        chk("rst.opcode", 16'(alu_opcode), 16'd4);
        chk("rst.done", 16'(done), 16'd0);
        chk("rst.err", 16'(err), 16'd0);
        chk("rst.zero", 16'(zero), 16'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel.ready", 16'(instr_ready), 16'd1);
        chk("rel.done", 16'(done), 16'd0);

        issue(OP_LDI, 3'd1, 3'd0, 3'd0, 9'h0FF, 1'b1, 1'b0, "ldi_r1");
        reg_is(3'd1, 9'h0FF, "r1");
        issue(OP_LDI, 3'd2, 3'd0, 3'd0, 9'h001, 1'b1, 1'b0, "ldi_r2");
        reg_is(3'd2, 9'h001, "r2");

        issue(OP_ADD, 3'd3, 3'd1, 3'd2, 9'h000, 1'b1, 1'b0, "add_r3");
        reg_is(3'd3, 9'h100, "r3");
        chk("add.zero", 16'(zero), 16'd0);
        chk("add.alu_a", 16'(alu_a), 16'h0FF);
        chk("add.alu_b", 16'(alu_b), 16'h001);
        chk("add.opcode", 16'(alu_opcode), 16'(OP_ADD));

        issue(OP_LDI, 3'd4, 3'd0, 3'd0, 9'h1FF, 1'b1, 1'b0, "ldi_r4");
        issue(OP_ADDI, 3'd5, 3'd4, 3'd7, 9'h001, 1'b1, 1'b0, "addi_r5");
        reg_is(3'd5, 9'h000, "r5_wrap");
        chk("addi.zero", 16'(zero), 16'd1);
        chk("addi.alu_b", 16'(alu_b), 16'h001);
        issue(OP_SUB, 3'd6, 3'd2, 3'd1, 9'h000, 1'b1, 1'b0, "sub_r6");
        reg_is(3'd6, 9'h102, "r6");
        chk("sub.zero", 16'(zero), 16'd0);

        issue(4'b1100, 3'd1, 3'd2, 3'd2, 9'h000, 1'b0, 1'b1, "illegal");
        reg_is(3'd1, 9'h0FF, "r1_kept");
        @(posedge clk); #1;
        chk("illegal.err_once", 16'(err), 16'd0);

        issue(OP_NOP, 3'd2, 3'd1, 3'd1, 9'h000, 1'b1, 1'b0, "nop");
        reg_is(3'd2, 9'h001, "r2_kept");
        reg_is(3'd6, 9'h102, "r6_kept");
        chk("nop.zero", 16'(zero), 16'd0);

        // Two queued instructions with valid held high; the second reads r7 written by the first.
        @(posedge clk); #1;
        chk("b2b.rdy0", 16'(instr_ready), 16'd1);
        instr_op = OP_LDI; instr_rd = 3'd7; instr_ra = 3'd0; instr_rb = 3'd0; instr_imm = 9'h055;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        chk("b2b.rdy1", 16'(instr_ready), 16'd0);
        instr_op = OP_ADD; instr_rd = 3'd7; instr_ra = 3'd7; instr_rb = 3'd7; instr_imm = 9'h000;
        @(posedge clk); #1;
        chk("b2b.rdy2", 16'(instr_ready), 16'd0);
        chk("b2b.done2", 16'(done), 16'd0);
        @(posedge clk); #1;
        chk("b2b.done3", 16'(done), 16'd1);
        chk("b2b.rdy3", 16'(instr_ready), 16'd1);
        reg_is(3'd7, 9'h055, "b2b.r7a");
        @(posedge clk); #1;
        instr_valid = 1'b0;
        chk("b2b.rdy4", 16'(instr_ready), 16'd0);
        chk("b2b.done4", 16'(done), 16'd0);
        @(posedge clk); #1;
        chk("b2b.done5", 16'(done), 16'd0);
        @(posedge clk); #1;
        chk("b2b.done6", 16'(done), 16'd1);
        reg_is(3'd7, 9'h0AA, "b2b.r7b");
        @(posedge clk); #1;
        chk("b2b.done7", 16'(done), 16'd0);
        chk("b2b.rdy7", 16'(instr_ready), 16'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("b2b.nodup", 16'(done), 16'd0);
        chk("b2b.idle", 16'(instr_ready), 16'd1);

        issue(OP_LDI, 3'd0, 3'd0, 3'd0, 9'h000, 1'b1, 1'b0, "ldi_r0");
        chk("ldi_r0.zero", 16'(zero), 16'd1);

        // Reset during EXEC of ADD r3 aborts it and clears the register file.
        @(posedge clk); #1;
        instr_op = OP_ADD; instr_rd = 3'd3; instr_ra = 3'd1; instr_rb = 3'd2; instr_imm = 9'h000;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        chk("abort.in_exec", 16'(instr_ready), 16'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("abort.ready", 16'(instr_ready), 16'd1);
        chk("abort.alu_a", 16'(alu_a), 16'd0);
        chk("abort.alu_b", 16'(alu_b), 16'd0);
        chk("abort.opcode", 16'(alu_opcode), 16'd4);
        chk("abort.zero", 16'(zero), 16'd0);
        chk("abort.done", 16'(done), 16'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort.rel_ready", 16'(instr_ready), 16'd1);
        chk("abort.rel_done", 16'(done), 16'd0);
        reg_is(3'd3, 9'h000, "abort.r3");
        reg_is(3'd1, 9'h000, "abort.r1");
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort.no_done", 16'(done), 16'd0);
        reg_is(3'd3, 9'h000, "abort.r3_late");

        issue(OP_LDI, 3'd3, 3'd0, 3'd0, 9'h033, 1'b1, 1'b0, "post_rst");
        reg_is(3'd3, 9'h033, "post_rst.r3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
